// File: rtl/cdb_grant_scheduler.sv
// Grants up to two CDB lanes per cycle to result-ready requesters (round-robin with age override).
// Latency: one registered stage from i_req to o_grant; a requester holds i_req until it sees o_grant.
module cdb_grant_scheduler #(
    parameter int         NUM_REQ      = 4,
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         MAX_WAIT     = 7
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic [1:0]           i_lane_en,
    input  logic [NUM_REQ-1:0]   i_req,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_grant_lane,
    output logic [1:0]           o_lane_valid,
    output logic [1:0][7:0]      o_lane_owner,
    output logic                 o_starved
);

    localparam int         IDXW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

    logic [IDXW-1:0]    rr_ptr;
    logic [IDXW-1:0]    rr_ptr_nxt;
    logic [3:0]         wait_cnt [NUM_REQ];
    logic [3:0]         wait_nxt [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] starved_set;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] grant_lane_nxt;
    logic [1:0]         lane_valid_nxt;
    logic [1:0][7:0]    lane_owner_nxt;
    logic               starved_nxt;
    logic               pick0_vld;
    logic               pick1_vld;
    logic [IDXW-1:0]    pick0_idx;
    logic [IDXW-1:0]    pick1_idx;
    logic               sel1_vld;
    logic [IDXW-1:0]    sel1_idx;

    // Requester index k positions after base, wrapping at NUM_REQ-1.
    function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDXW'(s);
    endfunction

    // Requests still high while their grant is showing are the handshake echo, not new work.
    always_comb begin
        elig = i_flush ? '0 : (i_req & ~o_grant);
        for (int n = 0; n < NUM_REQ; n++) begin
            starved_set[n] = elig[n] && (wait_cnt[n] >= MAX_WAIT_W);
        end
    end

    always_comb begin
        pick0_vld = 1'b0;
        pick0_idx = '0;
        pick1_vld = 1'b0;
        pick1_idx = '0;
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            if (starved_set[n]) begin
                pick0_vld = 1'b1;
                pick0_idx = IDXW'(n);
            end
        end
        if (!pick0_vld) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (elig[rr_idx(rr_ptr, k)]) begin
                    pick0_vld = 1'b1;
                    pick0_idx = rr_idx(rr_ptr, k);
                end
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[rr_idx(rr_ptr, k)] && !(pick0_vld && (rr_idx(rr_ptr, k) == pick0_idx))) begin
                pick1_vld = 1'b1;
                pick1_idx = rr_idx(rr_ptr, k);
            end
        end
    end

    // Picks fill enabled lanes in order, so lane1 takes the first pick when lane0 is withheld.
    always_comb begin
        sel1_vld       = i_lane_en[0] ? pick1_vld : pick0_vld;
        sel1_idx       = i_lane_en[0] ? pick1_idx : pick0_idx;
        grant_nxt      = '0;
        grant_lane_nxt = '0;
        lane_valid_nxt = 2'b00;
        lane_owner_nxt = {8'hFF, 8'hFF};
        rr_ptr_nxt     = rr_ptr;
        if (i_lane_en[0] && pick0_vld) begin
            grant_nxt[pick0_idx] = 1'b1;
            lane_valid_nxt[0]    = 1'b1;
            lane_owner_nxt[0]    = BASE_ADDRESS + 8'(pick0_idx);
            rr_ptr_nxt           = (pick0_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick0_idx + IDXW'(1);
        end
        if (i_lane_en[1] && sel1_vld) begin
            grant_nxt[sel1_idx]      = 1'b1;
            grant_lane_nxt[sel1_idx] = 1'b1;
            lane_valid_nxt[1]        = 1'b1;
            lane_owner_nxt[1]        = BASE_ADDRESS + 8'(sel1_idx);
            rr_ptr_nxt               = (sel1_idx == IDXW'(NUM_REQ - 1)) ? '0 : sel1_idx + IDXW'(1);
        end
    end

    always_comb begin
        starved_nxt = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (i_flush || !i_req[n] || grant_nxt[n]) begin
                wait_nxt[n] = 4'd0;
            end else if (elig[n] && (wait_cnt[n] != 4'd15)) begin
                wait_nxt[n] = wait_cnt[n] + 4'd1;
            end else begin
                wait_nxt[n] = wait_cnt[n];
            end
            if (wait_nxt[n] >= MAX_WAIT_W) starved_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_grant      <= '0;
            o_grant_lane <= '0;
            o_lane_valid <= 2'b00;
            o_lane_owner <= {8'hFF, 8'hFF};
            o_starved    <= 1'b0;
            rr_ptr       <= '0;
            for (int n = 0; n < NUM_REQ; n++) wait_cnt[n] <= 4'd0;
        end else begin
            o_grant      <= grant_nxt;
            o_grant_lane <= grant_lane_nxt;
            o_lane_valid <= lane_valid_nxt;
            o_lane_owner <= lane_owner_nxt;
            o_starved    <= starved_nxt;
            rr_ptr       <= rr_ptr_nxt;
            for (int n = 0; n < NUM_REQ; n++) wait_cnt[n] <= wait_nxt[n];
        end
    end

endmodule

// File: tb/tb_cdb_grant_scheduler.sv
// Directed and random stimulus against a queue-based reference scoreboard for the CDB scheduler.
module tb_cdb_grant_scheduler;

    localparam int         N    = 4;
    localparam int         IW   = 2;
    localparam logic [7:0] BASE = 8'h10;
    localparam int         MW   = 3;

    logic              i_clock;
    logic              i_reset_n;
    logic              i_flush;
    logic [1:0]        i_lane_en;
    logic [N-1:0]      i_req;
    logic [N-1:0]      o_grant;
    logic [N-1:0]      o_grant_lane;
    logic [1:0]        o_lane_valid;
    logic [1:0][7:0]   o_lane_owner;
    logic              o_starved;

    cdb_grant_scheduler #(.NUM_REQ(N), .BASE_ADDRESS(BASE), .MAX_WAIT(MW)) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_flush      (i_flush),
        .i_lane_en    (i_lane_en),
        .i_req        (i_req),
        .o_grant      (o_grant),
        .o_grant_lane (o_grant_lane),
        .o_lane_valid (o_lane_valid),
        .o_lane_owner (o_lane_owner),
        .o_starved    (o_starved)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [N-1:0]    grant;
        logic [N-1:0]    lane;
        logic [1:0]      lvld;
        logic [1:0][7:0] owner;
        logic            starved;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] m_grant;
    int           m_wait [N];
    int           m_rr;
    int           checks;
    int           failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = '0;
        m_rr    = 0;
        for (int n = 0; n < N; n++) m_wait[n] = 0;
        sb_q.delete();
    endtask

    // Reference: list the enabled lanes, list the picks (starved first, then round-robin), zip them.
    task automatic predict(output exp_t e);
        logic [N-1:0] el;
        int           picks[$];
        int           lanes[$];
        int           last;
        bit           any;
        el = i_flush ? '0 : (i_req & ~m_grant);
        if (i_lane_en[0]) lanes.push_back(0);
        if (i_lane_en[1]) lanes.push_back(1);
        for (int n = 0; n < N; n++) begin
            if (el[n] && m_wait[n] >= MW && picks.size() == 0) picks.push_back(n);
        end
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (el[IW'(idx)] && picks.size() < 2 && !(picks.size() == 1 && picks[0] == idx))
                picks.push_back(idx);
        end
        e.grant   = '0;
        e.lane    = '0;
        e.lvld    = 2'b00;
        e.owner   = {8'hFF, 8'hFF};
        e.starved = 1'b0;
        any  = 1'b0;
        last = m_rr;
        for (int i = 0; i < lanes.size() && i < picks.size(); i++) begin
            e.grant[IW'(picks[i])] = 1'b1;
            e.lane[IW'(picks[i])]  = (lanes[i] == 1);
            e.lvld[1'(lanes[i])]   = 1'b1;
            e.owner[1'(lanes[i])]  = BASE + 8'(picks[i]);
            last = picks[i];
            any  = 1'b1;
        end
        for (int n = 0; n < N; n++) begin
            if (i_flush || !i_req[n] || e.grant[n]) m_wait[n] = 0;
            else if (el[n] && m_wait[n] < 15)       m_wait[n] = m_wait[n] + 1;
            if (m_wait[n] >= MW) e.starved = 1'b1;
        end
        m_grant = e.grant;
        if (any) m_rr = (last + 1) % N;
    endtask

    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        predict(e);
        sb_q.push_back(e);
        @(posedge i_clock);
        #1;
        g = sb_q.pop_front();
        chk({tag, ".grant"},   32'(o_grant),      32'(g.grant));
        chk({tag, ".lane"},    32'(o_grant_lane), 32'(g.lane));
        chk({tag, ".lvld"},    32'(o_lane_valid), 32'(g.lvld));
        chk({tag, ".owner"},   32'(o_lane_owner), 32'(g.owner));
        chk({tag, ".starved"}, 32'(o_starved),    32'(g.starved));
    endtask

    initial begin
        bit seen3;
        checks    = 0;
        failures  = 0;
        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        i_lane_en = 2'b11;
        i_req     = 4'hF;
        model_reset();

        // Reset held with all requests pending.
        #12;
        chk("t1_rst_grant", 32'(o_grant), 32'h0);
        chk("t1_rst_lane",  32'(o_grant_lane), 32'h0);
        chk("t1_rst_lvld",  32'(o_lane_valid), 32'h0);
        chk("t1_rst_owner", 32'(o_lane_owner), 32'hFFFF);
        chk("t1_rst_starv", 32'(o_starved), 32'h0);
        i_reset_n = 1'b1;
        step("t1");
        chk("t1_grant01", 32'(o_grant), 32'h3);
        chk("t1_lane01",  32'(o_grant_lane), 32'h2);
        chk("t1_owner01", 32'(o_lane_owner), 32'h1110);

        // Continuous requests alternate between the pairs.
        step("t2a");
        chk("t2_pair23", 32'(o_grant), 32'hC);
        step("t2b");
        chk("t2_pair01", 32'(o_grant), 32'h3);
        step("t2c");
        chk("t2_pair23b", 32'(o_grant), 32'hC);

        i_req = 4'h0;
        step("idle1");
        step("idle2");

        // Only lane1 available.
        i_lane_en = 2'b10;
        i_req     = 4'b0101;
        step("t3a");
        chk("t3_grant0",  32'(o_grant), 32'h1);
        chk("t3_lvld",    32'(o_lane_valid), 32'h2);
        chk("t3_owner0",  32'(o_lane_owner), 32'h10FF);
        step("t3b");
        chk("t3_grant2",  32'(o_grant), 32'h4);
        chk("t3_owner2",  32'(o_lane_owner), 32'h12FF);
        i_req = 4'h0;
        step("idle3");
        step("idle4");

        // Single lane, everyone requesting: req3 must be served within a bounded window.
        i_lane_en = 2'b01;
        i_req     = 4'hF;
        seen3     = 1'b0;
        for (int i = 0; i < 6 && !seen3; i++) begin
            step("t4");
            if (o_grant[3]) seen3 = 1'b1;
        end
        chk("t4_req3_served", 32'(seen3), 32'h1);

        // Both lanes withheld: waits age until the starvation flag rises.
        i_lane_en = 2'b00;
        for (int i = 0; i < 3; i++) step("t4b_stall");
        chk("t4b_starved", 32'(o_starved), 32'h1);
        chk("t4b_nogrant", 32'(o_grant), 32'h0);
        i_lane_en = 2'b11;
        step("t4b_release");
        step("t4b_after");
        i_req = 4'h0;
        step("idle5");
        step("idle6");

        // Flush in the request cycle drops the grants and ages.
        i_req   = 4'b0011;
        i_flush = 1'b1;
        step("t5_flush");
        chk("t5_nogrant", 32'(o_grant), 32'h0);
        chk("t5_starved", 32'(o_starved), 32'h0);
        i_flush = 1'b0;
        step("t5_after");
        i_req = 4'h0;
        step("idle7");
        step("idle8");

        // Reset asserted while a grant is showing.
        i_req = 4'b0001;
        step("t6_pre");
        chk("t6_granted", 32'(o_grant), 32'h1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'(o_grant), 32'h0);
        chk("t6_async_owner", 32'(o_lane_owner), 32'hFFFF);
        chk("t6_async_lvld",  32'(o_lane_valid), 32'h0);
        model_reset();
        @(posedge i_clock);
        #3;
        i_reset_n = 1'b1;
        step("t6_post");
        chk("t6_reserved", 32'(o_grant), 32'h1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            i_req     = 4'($urandom);
            i_lane_en = 2'($urandom);
            i_flush   = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
